// File: rtl/tdc_stream_rx_if.sv
// Event/stream bundle between the TDC serial receiver and the image assembly logic.
// master = receiver side (consumes rx, produces events); slave = line driver / downstream consumer.
interface tdc_stream_rx_if;
  logic        rx;
  logic [47:0] data_out;
  logic        data_valid;
  logic        new_line;
  logic        new_frame;
  logic        frame_err;
  logic        header_err;
  logic        timeout_err;
  logic        busy;
  logic [15:0] data_count;
  logic [15:0] err_count;

  modport master (
    input  rx,
    output data_out, data_valid, new_line, new_frame,
    output frame_err, header_err, timeout_err, busy, data_count, err_count
  );

  modport slave (
    output rx,
    input  data_out, data_valid, new_line, new_frame,
    input  frame_err, header_err, timeout_err, busy, data_count, err_count
  );
endinterface

// File: rtl/tdc_stream_rx.sv
// 8N1 UART receiver that rebuilds 64-bit TDC records and splits them into data/line/frame events.
// Optional statistics counters are built only when TDC_RX_STATS_EN is defined.
module tdc_stream_rx #(
  parameter int CLK_PER_BIT = 100,
  parameter int GAP_TIMEOUT = 16 * CLK_PER_BIT
) (
  input  logic             clk,
  input  logic             rst,
  tdc_stream_rx_if.master  bus
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rxMeta_q, rxSync_q, rxPrev_q;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    byteCnt_q, byteCnt_d;
  logic [63:0]   rec_q, rec_d;
  logic          decPend_q, decPend_d;
  logic [GW-1:0] gapCnt_q, gapCnt_d;
  logic [47:0]   dataOut_q, dataOut_d;
  logic          dataValid_q, dataValid_d;
  logic          newLine_q, newLine_d;
  logic          newFrame_q, newFrame_d;
  logic          frameErr_q, frameErr_d;
  logic          headerErr_q, headerErr_d;
  logic          timeoutErr_q, timeoutErr_d;
  logic          fallEdge;

  assign fallEdge = rxPrev_q & ~rxSync_q;

  // Synchroniser flops preset to idle-high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q     <= 1'b1;
      rxSync_q     <= 1'b1;
      rxPrev_q     <= 1'b1;
      state_q      <= IDLE;
      clkCnt_q     <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      byteCnt_q    <= '0;
      rec_q        <= '0;
      decPend_q    <= 1'b0;
      gapCnt_q     <= '0;
      dataOut_q    <= '0;
      dataValid_q  <= 1'b0;
      newLine_q    <= 1'b0;
      newFrame_q   <= 1'b0;
      frameErr_q   <= 1'b0;
      headerErr_q  <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      rxMeta_q     <= bus.rx;
      rxSync_q     <= rxMeta_q;
      rxPrev_q     <= rxSync_q;
      state_q      <= state_d;
      clkCnt_q     <= clkCnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      byteCnt_q    <= byteCnt_d;
      rec_q        <= rec_d;
      decPend_q    <= decPend_d;
      gapCnt_q     <= gapCnt_d;
      dataOut_q    <= dataOut_d;
      dataValid_q  <= dataValid_d;
      newLine_q    <= newLine_d;
      newFrame_q   <= newFrame_d;
      frameErr_q   <= frameErr_d;
      headerErr_q  <= headerErr_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clkCnt_d     = clkCnt_q + CW'(1);
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    byteCnt_d    = byteCnt_q;
    rec_d        = rec_q;
    decPend_d    = 1'b0;
    gapCnt_d     = '0;
    dataOut_d    = dataOut_q;
    dataValid_d  = 1'b0;
    newLine_d    = 1'b0;
    newFrame_d   = 1'b0;
    frameErr_d   = 1'b0;
    headerErr_d  = 1'b0;
    timeoutErr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        if (fallEdge) begin
          state_d = START;
        end else if (byteCnt_q != 3'd0) begin
          // A stalled partial record is dropped so the next byte resyncs as byte 0.
          if (gapCnt_q == GW'(GAP_TIMEOUT - 1)) begin
            byteCnt_d    = '0;
            timeoutErr_d = 1'b1;
          end else begin
            gapCnt_d = gapCnt_q + GW'(1);
          end
        end
      end
      START: begin
        if (clkCnt_q == CW'(CLK_PER_BIT / 2 - 1)) begin
          clkCnt_d = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clkCnt_q == CW'(CLK_PER_BIT - 1)) begin
          clkCnt_d = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (clkCnt_q == CW'(CLK_PER_BIT - 1)) begin
          state_d = IDLE;
          if (rxSync_q) begin
            rec_d[{byteCnt_q, 3'b000} +: 8] = shift_q;
            byteCnt_d = byteCnt_q + 3'd1;
            decPend_d = (byteCnt_q == 3'd7);
          end else begin
            frameErr_d = 1'b1;
            byteCnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (decPend_q) begin
      if (rec_q[63:48] != 16'h0001) begin
        headerErr_d = 1'b1;
      end else if (rec_q[47:0] == {3{16'h000D}}) begin
        newLine_d = 1'b1;
      end else if (rec_q[47:0] == {3{16'h000E}}) begin
        newFrame_d = 1'b1;
      end else begin
        dataOut_d   = rec_q[47:0];
        dataValid_d = 1'b1;
      end
    end
  end

  assign bus.data_out    = dataOut_q;
  assign bus.data_valid  = dataValid_q;
  assign bus.new_line    = newLine_q;
  assign bus.new_frame   = newFrame_q;
  assign bus.frame_err   = frameErr_q;
  assign bus.header_err  = headerErr_q;
  assign bus.timeout_err = timeoutErr_q;
  assign bus.busy        = (state_q != IDLE) | (byteCnt_q != 3'd0);

`ifdef TDC_RX_STATS_EN
  logic [15:0] dataCount_q, errCount_q;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataCount_q <= '0;
      errCount_q  <= '0;
    end else begin
      if (dataValid_q && dataCount_q != 16'hFFFF)
        dataCount_q <= dataCount_q + 16'd1;
      if ((frameErr_q | headerErr_q | timeoutErr_q) && errCount_q != 16'hFFFF)
        errCount_q <= errCount_q + 16'd1;
    end
  end

  assign bus.data_count = dataCount_q;
  assign bus.err_count  = errCount_q;
`else
  assign bus.data_count = 16'h0000;
  assign bus.err_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_tdc_stream_rx.sv
// Randomised self-checking bench for tdc_stream_rx: drives UART bytes and compares the
// observed event stream against a record-level reference model.
module tb_tdc_stream_rx;

  localparam int CPB = 16;
  localparam int GAP = 16 * CPB;

  localparam logic [5:0] EV_DATA  = 6'b000001;
  localparam logic [5:0] EV_LINE  = 6'b000010;
  localparam logic [5:0] EV_FRAME = 6'b000100;
  localparam logic [5:0] EV_FERR  = 6'b001000;
  localparam logic [5:0] EV_HERR  = 6'b010000;
  localparam logic [5:0] EV_TO    = 6'b100000;

  typedef struct packed {
    logic [5:0]  kind;
    logic [47:0] data;
  } event_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdc_stream_rx_if bus();

  tdc_stream_rx #(.CLK_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  event_t      obsQ[$];
  event_t      expQ[$];
  logic [7:0]  partial[$];
  logic [47:0] lastData;
  int          expDataCount;
  int          expErrCount;
  logic [5:0]  monKind;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every pulse the DUT emits is logged for later comparison with the model.
  always @(negedge clk) begin
    monKind = {bus.timeout_err, bus.header_err, bus.frame_err, bus.new_frame, bus.new_line, bus.data_valid};
    if (monKind != 6'b0)
      obsQ.push_back({monKind, bus.data_valid ? bus.data_out : 48'h0});
  end

  function automatic void expectEvent(input logic [5:0] kind, input logic [47:0] data);
    expQ.push_back({kind, data});
    if (kind == EV_DATA) begin
      lastData = data;
      if (expDataCount < 65535) expDataCount++;
    end else if (kind == EV_FERR || kind == EV_HERR || kind == EV_TO) begin
      if (expErrCount < 65535) expErrCount++;
    end
  endfunction

  // Reference rule: first wire byte is the least significant; the last two form the header.
  function automatic void modelRecord();
    logic [15:0] header;
    logic [47:0] payload;
    header  = {partial[7], partial[6]};
    payload = {partial[5], partial[4], partial[3], partial[2], partial[1], partial[0]};
    if (header != 16'h0001)                 expectEvent(EV_HERR, 48'h0);
    else if (payload == 48'h000D000D000D)   expectEvent(EV_LINE, 48'h0);
    else if (payload == 48'h000E000E000E)   expectEvent(EV_FRAME, 48'h0);
    else                                    expectEvent(EV_DATA, payload);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic goodStop, input int gap);
    bus.rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      waitCycles(CPB);
    end
    bus.rx = goodStop;
    waitCycles(CPB);
    bus.rx = 1'b1;
    waitCycles(gap + 1);
    if (goodStop) begin
      partial.push_back(b);
      if (partial.size() == 8) begin
        modelRecord();
        partial.delete();
      end
    end else begin
      expectEvent(EV_FERR, 48'h0);
      partial.delete();
    end
  endtask

  task automatic sendRecord(input logic [63:0] rec);
    for (int k = 0; k < 8; k++)
      applyStimulus(rec[8*k +: 8], 1'b1, int'($urandom_range(0, 2*CPB)));
  endtask

  task automatic idleLong();
    waitCycles(GAP + 10);
    if (partial.size() != 0) begin
      expectEvent(EV_TO, 48'h0);
      partial.delete();
    end
  endtask

  task automatic doReset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    waitCycles(4);
    @(negedge clk);
    checkOutput("rst.pulses", {bus.timeout_err, bus.header_err, bus.frame_err,
                               bus.new_frame, bus.new_line, bus.data_valid}, 6'b0);
    checkOutput("rst.data_out", bus.data_out, 48'h0);
    checkOutput("rst.busy", bus.busy, 1'b0);
    checkOutput("rst.counts", {bus.data_count, bus.err_count}, 32'h0);
    rst = 1'b0;
    partial.delete();
    lastData     = 48'h0;
    expDataCount = 0;
    expErrCount  = 0;
    waitCycles(4);
  endtask

  task automatic compareEvents(input string tag);
    int n;
    waitCycles(3 * CPB);
    @(negedge clk);
    checkOutput({tag, ".events"}, 64'(obsQ.size()), 64'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".kind"}, obsQ[i].kind, expQ[i].kind);
      checkOutput({tag, ".data"}, obsQ[i].data, expQ[i].data);
    end
    checkOutput({tag, ".data_out"}, bus.data_out, lastData);
    checkOutput({tag, ".busy"}, bus.busy, partial.size() != 0);
`ifdef TDC_RX_STATS_EN
    checkOutput({tag, ".data_count"}, bus.data_count, 64'(expDataCount));
    checkOutput({tag, ".err_count"}, bus.err_count, 64'(expErrCount));
`else
    checkOutput({tag, ".counts"}, {bus.data_count, bus.err_count}, 32'h0);
`endif
    obsQ.delete();
    expQ.delete();
  endtask

  function automatic logic [63:0] randomData();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {16'h0001, r[47:0]};
  endfunction

  initial begin
    logic [63:0] rec;
    logic [15:0] hdr;
    int choice, nBytes;

    rst = 1'b1;
    bus.rx = 1'b1;
    doReset();

    sendRecord(64'h0001_9ABC_1234_5678);
    compareEvents("data");
    checkOutput("data.value", bus.data_out, 48'h9ABC_1234_5678);

    sendRecord({16'h0001, {3{16'h000D}}});
    sendRecord({16'h0001, {3{16'h000E}}});
    compareEvents("markers");

    sendRecord(64'h0002_0000_1111_2222);
    sendRecord(randomData());
    compareEvents("header");

    for (int k = 0; k < 3; k++) applyStimulus(8'($urandom), 1'b1, 4);
    idleLong();
    compareEvents("timeout");
    sendRecord(randomData());
    compareEvents("after_timeout");

    rec = randomData();
    for (int k = 0; k < 4; k++) applyStimulus(rec[8*k +: 8], 1'b1, 2);
    applyStimulus(rec[39:32], 1'b0, 2);
    sendRecord(randomData());
    compareEvents("frame_err");

    rec = randomData();
    for (int k = 0; k < 5; k++) applyStimulus(rec[8*k +: 8], 1'b1, 2);
    bus.rx = 1'b0;
    waitCycles(3 * CPB);
    doReset();
    compareEvents("rst_mid");
    sendRecord(randomData());
    compareEvents("after_rst");

    doReset();
    sendRecord(randomData());
    sendRecord(64'h0003_0000_0000_0001);
    sendRecord(randomData());
    applyStimulus(8'h55, 1'b0, 2);
    sendRecord(randomData());
    compareEvents("stats");

    for (int it = 0; it < 16; it++) begin
      choice = int'($urandom_range(0, 9));
      case (choice)
        0: sendRecord({16'h0001, {3{16'h000D}}});
        1: sendRecord({16'h0001, {3{16'h000E}}});
        2: begin
          hdr = 16'($urandom);
          if (hdr == 16'h0001) hdr = 16'h8001;
          rec = randomData();
          sendRecord({hdr, rec[47:0]});
        end
        3: begin
          nBytes = int'($urandom_range(1, 7));
          for (int k = 0; k < nBytes; k++) applyStimulus(8'($urandom), 1'b1, 3);
          idleLong();
          sendRecord(randomData());
        end
        4: begin
          nBytes = int'($urandom_range(0, 7));
          for (int k = 0; k < nBytes; k++) applyStimulus(8'($urandom), 1'b1, 3);
          applyStimulus(8'($urandom), 1'b0, 3);
          sendRecord(randomData());
        end
        default: sendRecord(randomData());
      endcase
      compareEvents("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
